voting_controller: RTL and testbench

VOTING_CONTROLLER -- requirements
Module: voting_controller

---
 rtl/voting_controller.sv | 161 ++++++++++++++++
 tb/tb_voting_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voting_controller.sv
// Ballot sequencing controller: arms one ballot per officer pulse, turns a single
// synchronized button rising edge into one vote strobe, rejects multi-presses and withdraws stale ballots.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | no ballot armed; waiting for i_ballot_en
// S_READY   | ballot armed; waiting for exactly one button press or timeout
// S_RELEASE | vote taken; waiting for every synchronized button to drop
// S_CLOSED  | poll closed; absorbing until reset
module voting_controller #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_ballot_en,
   input  logic             i_candidate_1,
   input  logic             i_candidate_2,
   input  logic             i_candidate_3,
   input  logic             i_voting_over,
   output logic             o_vote_1,
   output logic             o_vote_2,
   output logic             o_vote_3,
   output logic             o_ballot_ready,
   output logic             o_invalid,
   output logic             o_timeout,
   output logic             o_voting_over,
   output logic [CNT_W-1:0] o_ballot_count
);

   localparam int          TMR_W    = 16;
   localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_READY   = 2'd1,
      S_RELEASE = 2'd2,
      S_CLOSED  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [2:0]         r_sync1;
   logic [2:0]         r_sync2;
   logic [2:0]         r_sync3;
   logic [TMR_W-1:0]   r_tmr;
   logic [TMR_W-1:0]   w_tmr_nxt;
   logic [2:0]         r_vote;
   logic [2:0]         w_vote_nxt;
   logic               r_ballot_ready;
   logic               r_invalid;
   logic               w_invalid_nxt;
   logic               r_timeout;
   logic               w_timeout_nxt;
   logic               r_voting_over;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_cnt_inc;
   logic [2:0]         w_btn_raw;
   logic [2:0]         w_press;
   logic               w_press_one;
   logic               w_press_multi;
   logic               w_btn_any;
   logic               w_cnt_sat;

   assign w_btn_raw     = {i_candidate_3, i_candidate_2, i_candidate_1};
   assign w_press       = r_sync2 & ~r_sync3;
   assign w_press_one   = (w_press == 3'b001) || (w_press == 3'b010) || (w_press == 3'b100);
   assign w_press_multi = (w_press != 3'b000) && !w_press_one;
   assign w_btn_any     = (r_sync2 != 3'b000);
   assign w_cnt_sat     = &r_cnt;

   always_comb begin
      w_state_nxt   = r_state;
      w_vote_nxt    = 3'b000;
      w_invalid_nxt = 1'b0;
      w_timeout_nxt = 1'b0;
      w_tmr_nxt     = r_tmr;
      w_cnt_inc     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_voting_over) begin
               w_state_nxt = S_CLOSED;
            end else if (i_ballot_en) begin
               w_state_nxt = S_READY;
               w_tmr_nxt   = TMR_LOAD;
            end
         end
         S_READY: begin
            // A clean single press wins even against poll close, so the last voter is counted.
            if (w_press_one) begin
               w_vote_nxt  = w_press;
               w_cnt_inc   = 1'b1;
               w_state_nxt = i_voting_over ? S_CLOSED : S_RELEASE;
            end else if (i_voting_over) begin
               w_state_nxt = S_CLOSED;
            end else if (w_press_multi) begin
               w_invalid_nxt = 1'b1;
               w_tmr_nxt     = TMR_LOAD;
            end else if (r_tmr == '0) begin
               w_timeout_nxt = 1'b1;
               w_state_nxt   = S_IDLE;
            end else begin
               w_tmr_nxt = r_tmr - 16'd1;
            end
         end
         S_RELEASE: begin
            if (i_voting_over) begin
               w_state_nxt = S_CLOSED;
            end else if (!w_btn_any) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_CLOSED: begin
            w_state_nxt = S_CLOSED;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_sync1        <= 3'b000;
         r_sync2        <= 3'b000;
         r_sync3        <= 3'b000;
         r_tmr          <= '0;
         r_vote         <= 3'b000;
         r_ballot_ready <= 1'b0;
         r_invalid      <= 1'b0;
         r_timeout      <= 1'b0;
         r_voting_over  <= 1'b0;
         r_cnt          <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_sync1        <= w_btn_raw;
         r_sync2        <= r_sync1;
         r_sync3        <= r_sync2;
         r_tmr          <= w_tmr_nxt;
         r_vote         <= w_vote_nxt;
         r_ballot_ready <= (w_state_nxt == S_READY);
         r_invalid      <= w_invalid_nxt;
         r_timeout      <= w_timeout_nxt;
         r_voting_over  <= (w_state_nxt == S_CLOSED);
         if (w_cnt_inc && !w_cnt_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_vote_1       = r_vote[0];
   assign o_vote_2       = r_vote[1];
   assign o_vote_3       = r_vote[2];
   assign o_ballot_ready = r_ballot_ready;
   assign o_invalid      = r_invalid;
   assign o_timeout      = r_timeout;
   assign o_voting_over  = r_voting_over;
   assign o_ballot_count = r_cnt;

endmodule

// File: tb/tb_voting_controller.sv
// Bench for voting_controller: an 8-bit-count and a 2-bit-count instance share stimulus;
// a ballot-level scoreboard (expected strobe order, counts, pulses) judges both.
module tb_voting_controller;

   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_ballot_en = 1'b0;
   logic i_candidate_1 = 1'b0;
   logic i_candidate_2 = 1'b0;
   logic i_candidate_3 = 1'b0;
   logic i_voting_over = 1'b0;

   logic       o_vote_1, o_vote_2, o_vote_3, o_ballot_ready, o_invalid, o_timeout, o_voting_over;
   logic [7:0] o_ballot_count;
   logic       s_vote_1, s_vote_2, s_vote_3, s_ballot_ready, s_invalid, s_timeout, s_voting_over;
   logic [1:0] s_ballot_count;

   voting_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .i_ballot_en(i_ballot_en),
      .i_candidate_1(i_candidate_1), .i_candidate_2(i_candidate_2), .i_candidate_3(i_candidate_3),
      .i_voting_over(i_voting_over),
      .o_vote_1(o_vote_1), .o_vote_2(o_vote_2), .o_vote_3(o_vote_3),
      .o_ballot_ready(o_ballot_ready), .o_invalid(o_invalid), .o_timeout(o_timeout),
      .o_voting_over(o_voting_over), .o_ballot_count(o_ballot_count)
   );

   voting_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(2)) u_dut_sat (
      .clk(clk), .rst(rst), .i_ballot_en(i_ballot_en),
      .i_candidate_1(i_candidate_1), .i_candidate_2(i_candidate_2), .i_candidate_3(i_candidate_3),
      .i_voting_over(i_voting_over),
      .o_vote_1(s_vote_1), .o_vote_2(s_vote_2), .o_vote_3(s_vote_3),
      .o_ballot_ready(s_ballot_ready), .o_invalid(s_invalid), .o_timeout(s_timeout),
      .o_voting_over(s_voting_over), .o_ballot_count(s_ballot_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int exp_cnt = 0;
   int exp_inv = 0;
   int exp_to = 0;
   int n_inv = 0;
   int n_to = 0;
   int n_multi = 0;
   int n_strobe_s = 0;
   int q_exp[$];
   int q_obs[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic logic [2:0] votes();
      return {o_vote_3, o_vote_2, o_vote_1};
   endfunction

   // Strobe monitor on the quiet edge; the scoreboard compares against it at the end.
   always @(negedge clk) begin
      if (rst) begin
         if (o_vote_1) q_obs.push_back(1);
         if (o_vote_2) q_obs.push_back(2);
         if (o_vote_3) q_obs.push_back(3);
         if (int'(o_vote_1) + int'(o_vote_2) + int'(o_vote_3) > 1) n_multi++;
         if ({s_vote_3, s_vote_2, s_vote_1} != 3'b000) n_strobe_s++;
         if (o_invalid) n_inv++;
         if (o_timeout) n_to++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_btn(input logic [2:0] m);
      i_candidate_1 = m[0];
      i_candidate_2 = m[1];
      i_candidate_3 = m[2];
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_counts(input string tag);
      chk({tag, "_count"}, o_ballot_count, (exp_cnt > 255) ? 255 : exp_cnt);
      chk({tag, "_count_sat"}, s_ballot_count, (exp_cnt > 3) ? 3 : exp_cnt);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_outs"}, {o_vote_3, o_vote_2, o_vote_1, o_ballot_ready, o_invalid, o_timeout, o_voting_over}, 0);
      chk({tag, "_count"}, o_ballot_count, 0);
      chk({tag, "_outs_sat"}, {s_vote_3, s_vote_2, s_vote_1, s_ballot_ready, s_invalid, s_timeout, s_voting_over}, 0);
      chk({tag, "_count_sat"}, s_ballot_count, 0);
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b0;
      #1 chk_zero(tag);
      @(negedge clk);
      rst = 1'b1;
      exp_cnt = 0;
   endtask

   task automatic arm();
      i_ballot_en = 1'b1;
      @(negedge clk);
      i_ballot_en = 1'b0;
      chk("ready_on_arm", o_ballot_ready, 1);
   endtask

   // Raw press first sampled at edge k; strobe expected visible only after edge k+2.
   task automatic press_expect(input int c, input int hold, input bit close_now);
      logic [2:0] m;
      m = 3'(1 << (c - 1));
      set_btn(m);
      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         if (j == 3) begin
            chk("vote_strobe", votes(), m);
            if (close_now) chk("vote_then_closed", o_voting_over, 1);
         end else begin
            chk("vote_quiet", votes(), 0);
         end
         if (j == 2 && close_now) i_voting_over = 1'b1;
         if (j == hold) set_btn(3'b000);
      end
      exp_cnt++;
      q_exp.push_back(c);
      nclk(4);
      chk("ready_after_vote", o_ballot_ready, 0);
      chk_counts("vote");
   endtask

   task automatic do_vote(input int c, input int hold);
      arm();
      press_expect(c, hold, 1'b0);
   endtask

   task automatic invalid_then_vote(input logic [2:0] m, input int c);
      arm();
      set_btn(m);
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         chk("invalid_pulse", o_invalid, (j == 3) ? 1 : 0);
         chk("invalid_novote", votes(), 0);
         chk("invalid_ready", o_ballot_ready, 1);
         if (j == 3) set_btn(3'b000);
      end
      exp_inv++;
      nclk(2);
      press_expect(c, $urandom_range(1, 4), 1'b0);
   endtask

   task automatic held_then_press(input int c);
      set_btn(3'(1 << (c - 1)));
      nclk(4);
      arm();
      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         chk("held_novote", votes(), 0);
         chk("held_ready", o_ballot_ready, 1);
      end
      set_btn(3'b000);
      nclk(3);
      press_expect(c, $urandom_range(1, 4), 1'b0);
   endtask

   task automatic timeout_case();
      arm();
      for (int j = 1; j <= TO; j++) begin
         @(negedge clk);
         chk("timeout_pulse", o_timeout, (j == TO) ? 1 : 0);
         chk("timeout_ready", o_ballot_ready, (j < TO) ? 1 : 0);
      end
      exp_to++;
      nclk(1);
      chk("timeout_quiet", o_timeout, 0);
      chk_counts("timeout");
   endtask

   task automatic idle_noise();
      int hold;
      hold = $urandom_range(1, 4);
      set_btn(3'($urandom_range(1, 7)));
      for (int j = 1; j <= hold + 4; j++) begin
         @(negedge clk);
         chk("idle_novote", votes(), 0);
         chk("idle_notready", o_ballot_ready, 0);
         if (j == hold) set_btn(3'b000);
      end
   endtask

   initial begin
      logic [2:0] multi_masks [4];
      int         seq [5];
      int         n_before;
      multi_masks = '{3'd3, 3'd5, 3'd6, 3'd7};
      seq = '{2, 1, 3, 2, 2};

      rst = 1'b0;
      nclk(3);
      chk_zero("reset");
      rst = 1'b1;
      nclk(2);

      // Single c1 press held 3 cycles, then the rest of the six-vote sequence.
      do_vote(1, 3);
      foreach (seq[i]) do_vote(seq[i], 3);
      chk("seq_len", q_exp.size(), 6);

      // Button held from IDLE into READY gives no event until re-pressed.
      held_then_press(2);

      // Two buttons rising together, then c3 alone.
      invalid_then_vote(3'b101, 3);

      timeout_case();

      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 4))
            0: do_vote($urandom_range(1, 3), $urandom_range(1, 4));
            1: invalid_then_vote(multi_masks[$urandom_range(0, 3)], $urandom_range(1, 3));
            2: held_then_press($urandom_range(1, 3));
            3: timeout_case();
            default: idle_noise();
         endcase
         nclk($urandom_range(0, 3));
      end

      // Close the poll; further ballots and presses must be inert.
      i_voting_over = 1'b1;
      @(negedge clk);
      i_voting_over = 1'b0;
      chk("closed_flag", o_voting_over, 1);
      chk("closed_notready", o_ballot_ready, 0);
      n_before = q_obs.size();
      i_ballot_en = 1'b1;
      @(negedge clk);
      i_ballot_en = 1'b0;
      set_btn(3'b001);
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         chk("closed_novote", votes(), 0);
         chk("closed_notready2", o_ballot_ready, 0);
         if (j == 3) set_btn(3'b000);
         if (j == 5) set_btn(3'b101);
      end
      set_btn(3'b000);
      for (int j = 1; j <= TO + 4; j++) begin
         @(negedge clk);
         chk("closed_quiet", {o_invalid, o_timeout}, 0);
      end
      chk("closed_strobes", q_obs.size(), n_before);
      chk("closed_still", o_voting_over, 1);
      chk_counts("closed");

      // Reopen by reset; a press coincident with poll close still votes, then closes.
      async_reset("reset_closed");
      nclk(2);
      arm();
      press_expect(2, 3, 1'b1);
      i_voting_over = 1'b0;
      nclk(2);
      chk("close_after_vote", o_voting_over, 1);

      // Reset while in RELEASE with the button still held.
      async_reset("reset_closed2");
      nclk(2);
      arm();
      set_btn(3'b001);
      nclk(3);
      chk("release_vote", votes(), 3'b001);
      exp_cnt++;
      q_exp.push_back(1);
      chk_counts("release_vote");
      async_reset("reset_release");
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         chk("post_reset_novote", votes(), 0);
         chk("post_reset_notready", o_ballot_ready, 0);
      end
      set_btn(3'b000);
      nclk(4);
      chk_counts("post_reset");

      // Scoreboard comparison of everything the monitor saw.
      chk("strobe_total", q_obs.size(), q_exp.size());
      foreach (q_exp[i]) begin
         if (i < q_obs.size()) chk("strobe_order", q_obs[i], q_exp[i]);
         else chk("strobe_missing", 0, q_exp[i]);
      end
      chk("strobe_total_sat", n_strobe_s, q_exp.size());
      chk("invalid_total", n_inv, exp_inv);
      chk("timeout_total", n_to, exp_to);
      chk("onehot_violations", n_multi, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
